// File: rtl/rv32i_wb_pkg.sv
// Shared widths and the arbitration port-select type for the
// writeback arbiter and its register scoreboard.
package rv32i_wb_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;
  localparam int XLEN       = 32;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

  function automatic port_sel_e other_port(input port_sel_e p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/rv32i_scoreboard.sv
// Destination-register busy bits: set on reservation, cleared on
// register-file write, wiped on flush. x0 is never busy.
module rv32i_scoreboard
  import rv32i_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  res_valid,
  input  logic [REG_ADDR_W-1:0] res_addr,
  output logic                  res_ready,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                res_fire;
  logic                res_zero;

  assign res_zero  = (res_addr == '0);
  assign res_ready = res_zero | ~busy_q[res_addr];
  assign res_fire  = res_valid & res_ready & ~res_zero;

  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];

  // Set is applied after clear so a fresh reservation survives a
  // same-edge write to that register.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (flush) begin
      busy_d = '0;
    end else if (res_fire) begin
      busy_d[res_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/rv32i_wb_arbiter.sv
// Two-port round-robin writeback arbiter with registered RF write port.
// Optional forwarding outputs are enabled with WB_BYPASS_EN.
module rv32i_wb_arbiter
  import rv32i_wb_pkg::*;
#(
  parameter logic PRIO_RESET = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [XLEN-1:0]       a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [XLEN-1:0]       b_data,
  input  logic                  res_valid,
  input  logic [REG_ADDR_W-1:0] res_addr,
  output logic                  res_ready,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [REG_ADDR_W-1:0] rf_rd_addr,
  output logic [XLEN-1:0]       rf_rd_data,
  output logic                  rf_rd_we
`ifdef WB_BYPASS_EN
  ,
  output logic                  byp1_hit,
  output logic                  byp2_hit,
  output logic [XLEN-1:0]       byp_data
`endif
);

  port_sel_e             ptr_q;
  port_sel_e             ptr_d;
  logic                  we_q;
  logic                  we_d;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [REG_ADDR_W-1:0] addr_d;
  logic [XLEN-1:0]       data_q;
  logic [XLEN-1:0]       data_d;
  logic                  a_xfer;
  logic                  b_xfer;
  logic                  sb_rs1_busy;
  logic                  sb_rs2_busy;

  // At most one ready is high whenever both ports request.
  assign a_ready = ~b_valid | (ptr_q == PORT_A);
  assign b_ready = ~a_valid | (ptr_q == PORT_B);
  assign a_xfer  = a_valid & a_ready;
  assign b_xfer  = b_valid & b_ready;

  always_comb begin
    ptr_d = ptr_q;
    if (a_xfer && b_valid) begin
      ptr_d = other_port(PORT_A);
    end else if (b_xfer && a_valid) begin
      ptr_d = other_port(PORT_B);
    end
  end

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    unique case (1'b1)
      a_xfer: begin
        addr_d = a_addr;
        data_d = a_data;
        we_d   = (a_addr != '0);
      end
      b_xfer: begin
        addr_d = b_addr;
        data_d = b_data;
        we_d   = (b_addr != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= port_sel_e'(PRIO_RESET);
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign rf_rd_we   = we_q;
  assign rf_rd_addr = addr_q;
  assign rf_rd_data = data_q;

  rv32i_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .res_valid(res_valid),
    .res_addr (res_addr),
    .res_ready(res_ready),
    .clr_en   (we_q),
    .clr_addr (addr_q),
    .flush    (flush),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (sb_rs1_busy),
    .rs2_busy (sb_rs2_busy)
  );

`ifdef WB_BYPASS_EN
  assign byp1_hit = we_q & (rs1_addr == addr_q) & (rs1_addr != '0);
  assign byp2_hit = we_q & (rs2_addr == addr_q) & (rs2_addr != '0);
  assign byp_data = data_q;
  assign rs1_busy = sb_rs1_busy & ~byp1_hit;
  assign rs2_busy = sb_rs2_busy & ~byp2_hit;
`else
  assign rs1_busy = sb_rs1_busy;
  assign rs2_busy = sb_rs2_busy;
`endif

endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// Bench for rv32i_wb_arbiter: reference model plus directed checks.
module tb_rv32i_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [3:0]  a_addr = '0;
  logic [31:0] a_data = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [3:0]  b_addr = '0;
  logic [31:0] b_data = '0;
  logic        res_valid = 1'b0;
  logic [3:0]  res_addr = '0;
  logic        res_ready;
  logic        flush = 1'b0;
  logic [3:0]  rs1_addr = '0;
  logic [3:0]  rs2_addr = '0;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [3:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        rf_rd_we;
`ifdef WB_BYPASS_EN
  logic        byp1_hit;
  logic        byp2_hit;
  logic [31:0] byp_data;
`endif

  int checks = 0;
  int errors = 0;

  rv32i_wb_arbiter #(.PRIO_RESET(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .res_valid (res_valid),
    .res_addr  (res_addr),
    .res_ready (res_ready),
    .flush     (flush),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data),
    .rf_rd_we  (rf_rd_we)
`ifdef WB_BYPASS_EN
    ,
    .byp1_hit  (byp1_hit),
    .byp2_hit  (byp2_hit),
    .byp_data  (byp_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: state of the register-file port and busy set.
  logic [15:0] m_busy;
  logic        m_turn_b;
  logic        m_we;
  logic [3:0]  m_addr;
  logic [31:0] m_data;

  logic        n_go;
  logic        n_win_b;
  logic [3:0]  n_addr;
  logic [31:0] n_data;
  logic [15:0] n_busy;

  always_comb begin
    n_go    = a_valid | b_valid;
    n_win_b = (a_valid && b_valid) ? m_turn_b : b_valid;
    n_addr  = n_win_b ? b_addr : a_addr;
    n_data  = n_win_b ? b_data : a_data;
    n_busy  = m_busy;
    if (m_we) n_busy[m_addr] = 1'b0;
    if (flush) n_busy = '0;
    else if (res_valid && res_addr != 0 && !m_busy[res_addr])
      n_busy[res_addr] = 1'b1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   <= '0;
      m_turn_b <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_data   <= '0;
    end else begin
      m_busy <= n_busy;
      m_we   <= n_go && (n_addr != 0);
      if (n_go) begin
        m_addr <= n_addr;
        m_data <= n_data;
      end
      if (a_valid && b_valid) m_turn_b <= ~m_turn_b;
    end
  end

  function automatic logic hit(input logic [3:0] rs);
`ifdef WB_BYPASS_EN
    return m_we && rs == m_addr && rs != 0;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    chk("a_ready", a_ready, !b_valid || !m_turn_b);
    chk("b_ready", b_ready, !a_valid || m_turn_b);
    chk("res_ready", res_ready, res_addr == 0 || !m_busy[res_addr]);
    chk("rs1_busy", rs1_busy, m_busy[rs1_addr] && !hit(rs1_addr));
    chk("rs2_busy", rs2_busy, m_busy[rs2_addr] && !hit(rs2_addr));
    chk("rf_rd_we", rf_rd_we, m_we);
    if (m_we || rst) begin
      chk("rf_rd_addr", rf_rd_addr, m_addr);
      chk("rf_rd_data", rf_rd_data, m_data);
    end
`ifdef WB_BYPASS_EN
    chk("byp1_hit", byp1_hit, hit(rs1_addr));
    chk("byp2_hit", byp2_hit, hit(rs2_addr));
    chk("byp_data", byp_data, m_data);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic gq [4];

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_we", rf_rd_we, 0);
    chk("rst_addr", rf_rd_addr, 0);
    chk("rst_data", rf_rd_data, 0);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_res_ready", res_ready, 1);

    step();
    rst = 1'b0;
    a_valid = 1'b1; a_addr = 4'd5; a_data = 32'h1111_1111;
    step();
    a_valid = 1'b0;
    @(negedge clk);
    chk("first_we", rf_rd_we, 1);
    chk("first_addr", rf_rd_addr, 5);
    chk("first_data", rf_rd_data, 32'h1111_1111);

    step();
    a_valid = 1'b1; a_addr = 4'd1; a_data = 32'hAAAA_0001;
    b_valid = 1'b1; b_addr = 4'd2; b_data = 32'hBBBB_0002;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gq[i] = !(a_valid && a_ready);
      chk("rr_we", rf_rd_we, (i > 0) ? 1 : 0);
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    chk("rr_we_last", rf_rd_we, 1);
    chk("rr_grant0", gq[0], 0);
    chk("rr_grant1", gq[1], 1);
    chk("rr_grant2", gq[2], 0);
    chk("rr_grant3", gq[3], 1);

    step();
    res_valid = 1'b1; res_addr = 4'd7; rs1_addr = 4'd7;
    step();
    res_valid = 1'b0;
    @(negedge clk);
    chk("x7_busy", rs1_busy, 1);
    step();
    b_valid = 1'b1; b_addr = 4'd7; b_data = 32'h7777_7777;
    step();
    b_valid = 1'b0;
    @(negedge clk);
    chk("x7_wb_we", rf_rd_we, 1);
`ifdef WB_BYPASS_EN
    chk("x7_wb_busy", rs1_busy, 0);
    chk("x7_byp_hit", byp1_hit, 1);
    chk("x7_byp_data", byp_data, 32'h7777_7777);
`else
    chk("x7_wb_busy", rs1_busy, 1);
`endif
    step();
    @(negedge clk);
    chk("x7_after", rs1_busy, 0);

    res_valid = 1'b1; res_addr = 4'd3;
    step();
    @(negedge clk);
    chk("x3_res_blocked", res_ready, 0);
    res_addr = 4'd0;
    #1;
    chk("x0_res_ready", res_ready, 1);
    step();
    res_valid = 1'b0; rs1_addr = 4'd0; rs2_addr = 4'd3;
    #1;
    chk("x0_not_busy", rs1_busy, 0);
    chk("x3_still_busy", rs2_busy, 1);

    res_valid = 1'b1; res_addr = 4'd2;
    step();
    res_addr = 4'd4;
    step();
    flush = 1'b1; res_addr = 4'd9;
    a_valid = 1'b1; a_addr = 4'd2; a_data = 32'h2222_2222;
    step();
    flush = 1'b0; res_valid = 1'b0; a_valid = 1'b0;
    rs1_addr = 4'd2; rs2_addr = 4'd9;
    @(negedge clk);
    chk("flush_wb_we", rf_rd_we, 1);
    chk("flush_wb_addr", rf_rd_addr, 2);
    chk("flush_x2", rs1_busy, 0);
    chk("flush_x9", rs2_busy, 0);
    rs1_addr = 4'd4; rs2_addr = 4'd3;
    #1;
    chk("flush_x4", rs1_busy, 0);
    chk("flush_x3", rs2_busy, 0);

    step();
    a_valid = 1'b1; a_addr = 4'd0; a_data = 32'hDEAD_0000;
    #1;
    chk("x0_a_ready", a_ready, 1);
    step();
    a_valid = 1'b0;
    @(negedge clk);
    chk("x0_no_we", rf_rd_we, 0);
    step();
    a_valid = 1'b1; a_addr = 4'd6; a_data = 32'h6666_6666;
    step();
    a_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_we", rf_rd_we, 0);
    chk("midrst_addr", rf_rd_addr, 0);
    step();
    rst = 1'b0;

    for (int i = 0; i < 60; i++) begin
      a_valid   = 1'($urandom_range(0, 1));
      a_addr    = 4'($urandom_range(0, 15));
      a_data    = $urandom;
      b_valid   = 1'($urandom_range(0, 1));
      b_addr    = 4'($urandom_range(0, 15));
      b_data    = $urandom;
      res_valid = 1'($urandom_range(0, 1));
      res_addr  = 4'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 9) == 0);
      rs1_addr  = 4'($urandom_range(0, 15));
      rs2_addr  = 4'($urandom_range(0, 15));
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_wb_arbiter.md
RV32I_WB_ARBITER -- requirements
Module: rv32i_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-002 The block SHALL have parameter: PRIO_RESET, 0, port favoured first after reset (0=A, 1=B).
REQ-003 Ports: clk  in  1  clock, rising edge.
REQ-004 Ports: rst  in  1  asynchronous active-high reset.
REQ-005 Ports: a_valid in 1, a_ready out 1, a_addr in 4, a_data in 32: port A writeback request (execute stage).
REQ-006 Ports: b_valid in 1, b_ready out 1, b_addr in 4, b_data in 32: port B writeback request (load unit).
REQ-007 Ports: res_valid in 1, res_addr in 4, res_ready out 1: destination reservation from issue.
REQ-008 Ports: flush in 1: discard all reservations.
REQ-009 Ports: rs1_addr in 4, rs2_addr in 4, rs1_busy out 1, rs2_busy out 1: hazard query.
REQ-010 Ports: rf_rd_addr out 4, rf_rd_data out 32, rf_rd_we out 1: register-file write port.

Function
REQ-011 A transfer on a port SHALL occur when its valid and ready are both 1 at a rising edge.
REQ-012 a_ready SHALL be 1 when b_valid=0 or ptr=A; b_ready SHALL be 1 when a_valid=0 or ptr=B; ready is combinational, never both transfers in one cycle.
REQ-013 Round-robin: after a transfer on port X while the other port was also valid, ptr SHALL point to the other port; otherwise ptr holds.
REQ-014 A transfer at edge N SHALL drive rf_rd_addr/rf_rd_data with the accepted values and rf_rd_we=1 for exactly the cycle after edge N; rf_rd_we=0 in cycles with no prior transfer.
REQ-015 A transfer with addr=0 SHALL be accepted but rf_rd_we SHALL stay 0 for that cycle.
REQ-016 Scoreboard: busy bits for x1..x15; x0 SHALL never be busy.
REQ-017 res_ready SHALL be 1 when res_addr=0 or busy[res_addr]=0; reservation of x0 is a no-op.
REQ-018 res_valid&res_ready at an edge SHALL set busy[res_addr] at that edge.
REQ-019 The edge ending a cycle with rf_rd_we=1 SHALL clear busy[rf_rd_addr]; a set and clear of different registers at one edge SHALL both take effect.
REQ-020 flush at an edge SHALL clear all busy bits and drop any simultaneous reservation; accepted writes already in flight SHALL still reach the register file.
REQ-021 rs1_busy/rs2_busy SHALL equal busy[rs1_addr]/busy[rs2_addr] combinationally (0 for x0).
REQ-022 Writes to registers not reserved SHALL commit normally and leave busy bits unchanged.

Reset
REQ-023 While rst=1: rf_rd_we=0, rf_rd_addr=0, rf_rd_data=0, all busy bits 0, ptr=PRIO_RESET; reset asserted mid-transfer SHALL drop the pending write.
REQ-024 With no requests pending after reset, a_ready=b_ready=1 and res_ready=1.

Configuration
REQ-025 Macro WB_BYPASS_EN: when defined, outputs byp1_hit out 1, byp2_hit out 1, byp_data out 32 SHALL exist; bypN_hit=rf_rd_we & rsN_addr=rf_rd_addr & rsN_addr!=0, byp_data=rf_rd_data, and rsN_busy SHALL be 0 when bypN_hit=1.
REQ-026 Without WB_BYPASS_EN those ports SHALL be absent and rsN_busy SHALL clear only the cycle after rf_rd_we.

Structure
REQ-027 Package rv32i_wb_pkg SHALL hold REG_ADDR_W=4, NUM_REGS=16, XLEN=32 and the port-select type (A, B).
REQ-028 Busy-bit storage, set/clear/flush logic SHALL be sub-module rv32i_scoreboard; arbitration and output register stay in the top.

Verification
REQ-029 Reset release, a_valid=1 a_addr=5 a_data=0x11111111 -> next cycle rf_rd_we=1, rf_rd_addr=5, rf_rd_data=0x11111111.
REQ-030 a_valid=b_valid=1 held 4 cycles, PRIO_RESET=0 -> grants A,B,A,B; rf_rd_we high 4 consecutive cycles.
REQ-031 Reserve x7, query rs1_addr=7 -> rs1_busy=1; b writes x7 -> rs1_busy=0 the cycle after rf_rd_we (same cycle with WB_BYPASS_EN, byp1_hit=1).
REQ-032 busy[x3]=1, res_valid=1 res_addr=3 -> res_ready=0; res_addr=0 -> res_ready=1, no busy change.
REQ-033 Reserve x2,x4; flush with res_valid=1 res_addr=9 -> all busy 0, x9 not reserved; in-flight write to x2 still asserts rf_rd_we.
REQ-034 a_addr=0 transfer -> a_ready=1, rf_rd_we=0 next cycle; rst asserted the cycle after a transfer -> rf_rd_we=0 immediately.
